bcd_display_scanner: RTL and testbench
======================================

# bcd_display_scanner

Four-digit multiplexed seven-segment driver sitting directly downstream of the cascaded synchronous BCD decade counters. On a load strobe it snapshots four BCD digits, then time-multiplexes them onto a single shared segment bus with one-hot digit enables. It also flags invalid BCD codes. Optional leading-zero blanking is provided.

## Interface
- SCAN_DIV, 4: clk cycles each digit is displayed; legal range 1..65535.

- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset; one clock; sampled on rising clk
- load  input  1  when 1 at a rising edge, bcd_in is captured into the snapshot
- bcd_in  input  16  four BCD digits; [3:0] = digit0 (units) … [15:12] = digit3
- seg  output  7  segment drive, active-high; bit0=a … bit6=g
- an  output  4  digit enable, one-hot, active-high; an[k] selects digit k
- err  output  1  1 when the current snapshot holds any nibble > 9

## Operation
- State registers:
  - snap[15:0], reset 0.
  - cnt (prescaler, 0..SCAN_DIV-1), reset 0.
  - idx[1:0], reset 0.
  - err, reset 0.
- Snapshot:
  - load=1 at an edge: snap <= bcd_in and err <= (any nibble of bcd_in > 9).
  - Otherwise snap and err hold.
  - load does not disturb cnt or idx.
- Prescaler and scan:
  - cnt increments every cycle.
  - When cnt == SCAN_DIV-1, cnt wraps to 0 and idx advances 0→1→2→3→0.
  - With SCAN_DIV=1, idx advances every cycle.
- Outputs are combinational from registered state only (no input-to-output path):
  - an = 1 << idx.
  - seg = decode(snap nibble idx).
- Decode (hex of seg):
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F.
  - 10..15→40 (dash, g only).
- Simultaneous load and idx advance on the same edge: both take effect. The next cycle shows the new snapshot's nibble at the new idx.
- Reset has priority over load. An edge with reset_n=0 mid-frame forces snap=0, cnt=0, idx=0, err=0; load is ignored.
- Reset outputs: an=4'b0001, seg=7'h3F, err=0.

## Timing
- Load-to-display latency: 1 cycle. A snapshot captured at edge N is visible on seg from cycle N+1 whenever idx selects that digit.
- err is valid the cycle after the load edge.
- Each digit dwells exactly SCAN_DIV cycles; a full frame is 4·SCAN_DIV cycles.
- After reset release, digit0 is shown for SCAN_DIV cycles, then digits 1, 2, 3 in order.
- an changes only on the edge where cnt wraps. Exactly one an bit is high in every cycle, including the reset cycle.

## Configuration
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit k (k=3,2,1) is blanked (seg=7'h00, an still asserted) when snap nibbles k..3 are all zero.
  - Digit0 is never blanked.
  - An invalid nibble counts as nonzero: it is not blanked and stops blanking of lower digits.
- Undefined: no blanking; zeros display as 7'h3F.
- All other behaviour is identical in both builds.

## Test plan
- Reset: hold reset_n=0 for 2 cycles with load=1, bcd_in=16'h1234 -> an=0001, seg=3F, err=0 throughout. Snapshot stays 0 after release.
- Scan order, SCAN_DIV=4: load 16'h4321, then observe 16 cycles -> an=0001/seg=06 ×4, 0010/5B ×4, 0100/4F ×4, 1000/66 ×4, then repeats.
- Invalid code: load 16'h0A09 -> err=1 next cycle; digit2 seg=40, digit0 seg=6F. A later load of 16'h0000 clears err to 0.
- Blanking: load 16'h0007.
  - With LEADING_ZERO_BLANK_EN: digits 3..1 seg=00, digit0 seg=07.
  - Without it: digits 3..1 seg=3F.
  - Also load 16'h0105 with the macro -> digit3=00, digit2=06, digit1=3F, digit0=6D.
- Load on wrap edge and mid-frame reset:
  - Assert load=16'h9999 on the edge where idx goes 1→2 -> next cycle an=0100, seg=6F.
  - Reset at idx=3, cnt=2 -> next cycle an=0001, seg=3F, and digit0 dwells a full SCAN_DIV.
- SCAN_DIV=1: load 16'h8765 -> an rotates every cycle with seg 6D, 7D, 07, 7F.

Source files
------------

// File: rtl/bcd_display_scanner_if.sv
// ----------------------------------------------------------------------------
// Module   : bcd_display_scanner_if
// Brief    : Load/snapshot inputs and segment/digit/err outputs of the scanner.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface bcd_display_scanner_if;
  logic        load;
  logic [15:0] bcd_in;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        err;

  modport master (output load, output bcd_in, input seg, input an, input err);
  modport slave  (input load, input bcd_in, output seg, output an, output err);
endinterface

`default_nettype wire

// File: rtl/bcd_display_scanner.sv
// ----------------------------------------------------------------------------
// Module   : bcd_display_scanner
// Brief    : Snapshots four BCD digits and scans them onto a shared 7-segment
//            bus with one-hot digit enables. The optional macro
//            LEADING_ZERO_BLANK_EN enables leading-zero blanking.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bcd_display_scanner #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  wire logic            clk,
  input  wire logic            reset_n,
  bcd_display_scanner_if.slave bus
);

  localparam logic [15:0] c_DIV_LAST = 16'(SCAN_DIV - 1);

  logic [15:0] r_snap;
  logic [15:0] r_cnt;
  logic [1:0]  r_idx;
  logic        r_err;

  logic        w_wrap;
  logic        w_bad;
  logic [3:0]  w_nib;
  logic [6:0]  w_dec;
  logic        w_blank;

  assign w_wrap = (r_cnt == c_DIV_LAST);
  assign w_bad  = (bus.bcd_in[3:0]   > 4'd9) || (bus.bcd_in[7:4]   > 4'd9) ||
                  (bus.bcd_in[11:8]  > 4'd9) || (bus.bcd_in[15:12] > 4'd9);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_snap <= '0;
      r_cnt  <= '0;
      r_idx  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (bus.load) begin
        r_snap <= bus.bcd_in;
        r_err  <= w_bad;
      end
      if (w_wrap) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign w_nib = r_snap[{r_idx, 2'b00} +: 4];

  always_comb begin
    w_dec = 7'h40;
    case (w_nib)
      4'd0:    w_dec = 7'h3F;
      4'd1:    w_dec = 7'h06;
      4'd2:    w_dec = 7'h5B;
      4'd3:    w_dec = 7'h4F;
      4'd4:    w_dec = 7'h66;
      4'd5:    w_dec = 7'h6D;
      4'd6:    w_dec = 7'h7D;
      4'd7:    w_dec = 7'h07;
      4'd8:    w_dec = 7'h7F;
      4'd9:    w_dec = 7'h6F;
      default: w_dec = 7'h40;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // An invalid nibble is nonzero, so it naturally stops blanking below it.
  always_comb begin
    w_blank = 1'b0;
    case (r_idx)
      2'd3:    w_blank = (r_snap[15:12] == 4'd0);
      2'd2:    w_blank = (r_snap[15:8]  == 8'd0);
      2'd1:    w_blank = (r_snap[15:4]  == 12'd0);
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  assign bus.seg = w_blank ? 7'h00 : w_dec;
  assign bus.an  = 4'b0001 << r_idx;
  assign bus.err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bcd_display_scanner.sv
// ----------------------------------------------------------------------------
// Module   : tb_bcd_display_scanner
// Brief    : Bench for bcd_display_scanner at SCAN_DIV=4 and SCAN_DIV=1.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bcd_display_scanner;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] bcd_in = '0;

  int n_pass = 0;
  int n_total = 0;

  // Reference state: snapshot, error flag, cycles elapsed since reset release.
  logic [15:0] m_snap = '0;
  logic        m_err = 1'b0;
  int          m_t = 0;

  bcd_display_scanner_if if4 ();
  bcd_display_scanner_if if1 ();

  assign if4.load   = load;
  assign if4.bcd_in = bcd_in;
  assign if1.load   = load;
  assign if1.bcd_in = bcd_in;

  bcd_display_scanner #(.SCAN_DIV(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(if4));
  bcd_display_scanner #(.SCAN_DIV(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  function automatic logic any_bad(input logic [15:0] v);
    for (int k = 0; k < 4; k++)
      if (((v >> (4 * k)) & 16'hF) > 9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int k);
    int d;
    d = int'((v >> (4 * k)) & 16'hF);
`ifdef LEADING_ZERO_BLANK_EN
    if (k > 0 && (v >> (4 * k)) == 16'd0) return 7'h00;
`endif
    return seg_of(d);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h (t=%0d)", tag, obs, exp, m_t);
  endtask

  task automatic check_dut(input int div);
    int k;
    k = (m_t / div) % 4;
    if (div == 4) begin
      check("an4",  16'(if4.an),  16'(4'b0001 << k));
      check("seg4", 16'(if4.seg), 16'(exp_seg(m_snap, k)));
      check("err4", 16'(if4.err), 16'(m_err));
    end else begin
      check("an1",  16'(if1.an),  16'(4'b0001 << k));
      check("seg1", 16'(if1.seg), 16'(exp_seg(m_snap, k)));
      check("err1", 16'(if1.err), 16'(m_err));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset_n) begin
      m_snap = '0;
      m_err  = 1'b0;
      m_t    = 0;
    end else begin
      if (load) begin
        m_snap = bcd_in;
        m_err  = any_bad(bcd_in);
      end
      m_t++;
    end
    @(negedge clk);
    check_dut(4);
    check_dut(1);
  endtask

  task automatic load_once(input logic [15:0] v);
    load = 1'b1;
    bcd_in = v;
    step();
    load = 1'b0;
  endtask

  initial begin
    // Reset held two cycles with a load pending; load must be ignored.
    reset_n = 1'b0; load = 1'b1; bcd_in = 16'h1234;
    step();
    step();
    check("rst_an", 16'(if4.an), 16'h0001);
    check("rst_seg", 16'(if4.seg), 16'h003F);
    load = 1'b0; reset_n = 1'b1;
    repeat (6) step();

    load_once(16'h4321);
    repeat (20) step();

    load_once(16'h0A09);
    check("bad_err", 16'(if4.err), 16'h0001);
    repeat (16) step();
    load_once(16'h0000);
    check("clr_err", 16'(if4.err), 16'h0000);
    repeat (4) step();

    load_once(16'h0007);
    repeat (16) step();
    load_once(16'h0105);
    repeat (16) step();

    // Load on the edge where idx moves 1 -> 2.
    for (int i = 0; i < 16 && (m_t % 16) != 7; i++) step();
    load_once(16'h9999);
    check("wrap_an", 16'(if4.an), 16'h0004);
    check("wrap_seg", 16'(if4.seg), 16'h006F);
    repeat (6) step();

    // Reset mid-frame at idx=3, cnt=2.
    for (int i = 0; i < 16 && (m_t % 16) != 14; i++) step();
    reset_n = 1'b0;
    step();
    check("mrst_an", 16'(if4.an), 16'h0001);
    check("mrst_seg", 16'(if4.seg), 16'h003F);
    reset_n = 1'b1;
    repeat (8) step();

    load_once(16'h8765);
    repeat (8) step();

    for (int i = 0; i < 300; i++) begin
      logic [15:0] v;
      if ($urandom_range(0, 2) == 0) v = 16'($urandom);
      else begin
        v = '0;
        for (int k = 0; k < 4; k++) v[4*k +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 1) == 1) v = v >> (4 * $urandom_range(1, 3));
      end
      bcd_in  = v;
      load    = ($urandom_range(0, 5) == 0);
      reset_n = ($urandom_range(0, 60) != 0);
      step();
    end
    load = 1'b0; reset_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
